// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
// Covers the FSM state encoding, the lane/accumulator widths and the beat counter.
package fc_layer_sequencer_pkg;

   localparam int unsigned NUM_LANES  = 4;
   localparam int unsigned ACC_W      = 26;
   localparam int unsigned BEAT_CNT_W = 16;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FLUSH,
      S_RD,
      S_MAC,
      S_CAPT,
      S_BRD,
      S_BIAS,
      S_WR,
      S_FIN
   } seq_state_e;

   function automatic logic is_beat(input seq_state_e s);
      return (s == S_FLUSH) || (s == S_MAC) || (s == S_BIAS);
   endfunction

   // Lane mask for the final feature word of a neuron.
   function automatic logic [NUM_LANES-1:0] tail_mask(input int unsigned bytes);
      int unsigned r;
      logic [NUM_LANES-1:0] m;
      r = bytes % NUM_LANES;
      m = '1;
      if (r != 0) m = NUM_LANES'((1 << r) - 1);
      return m;
   endfunction

endpackage

// File: rtl/fc_layer_sequencer_handshake.sv
// Owns one controller beat: holds mac_en, masks the stale first-cycle done,
// and aborts the beat when the controller stays silent for TIMEOUT cycles.
module mac_beat_handshake
   import fc_layer_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic issue_i,
   input  logic mac_done_i,
   output logic mac_en_o,
   output logic complete_o,
   output logic timeout_o
);

   logic                  active_q, active_d;
   logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q is the 1-based cycle index inside the current beat.
   always_comb begin
      complete_o = active_q && (cnt_q != BEAT_CNT_W'(1)) && mac_done_i;
      timeout_o  = active_q && !complete_o && (cnt_q >= BEAT_CNT_W'(TIMEOUT));
      active_d   = active_q;
      cnt_d      = cnt_q;
      if (issue_i) begin
         active_d = 1'b1;
         cnt_d    = BEAT_CNT_W'(1);
      end else if (complete_o || timeout_o) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end else if (active_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mac_en_o = active_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Command-side sequencer for the 4-lane MAC controller: walks groups of four
// neurons, issues FLUSH/MAC/BIAS beats and writes each packed group result.
module fc_layer_sequencer
   import fc_layer_sequencer_pkg::*;
#(
   parameter int unsigned IN_BYTES   = 784,
   parameter int unsigned OUT_GROUPS = 4,
   parameter int unsigned AW         = 16,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 relu_en,
   output logic                 busy,
   output logic                 layer_done,
   output logic                 error,
   output logic [AW-1:0]        feat_addr,
   input  logic [31:0]          feat_rdata,
   output logic [AW-1:0]        wgt_addr,
   input  logic [31:0]          wgt_rdata,
   output logic [AW-1:0]        bias_addr,
   input  logic [31:0]          bias_rdata,
   output logic                 out_we,
   output logic [AW-1:0]        out_addr,
   output logic [31:0]          out_wdata,
   output logic                 mac_en,
   output logic                 mac_flush,
   output logic                 mac_bias_add,
   output logic                 mac_relu,
   output logic [NUM_LANES-1:0] mac_valid,
   output logic [31:0]          mac_input_feature,
   output logic [31:0]          mac_weight,
   output logic [31:0]          mac_bias,
   output logic [ACC_W-1:0]     mac_result0,
   output logic [ACC_W-1:0]     mac_result1,
   output logic [ACC_W-1:0]     mac_result2,
   output logic [ACC_W-1:0]     mac_result3,
   input  logic [ACC_W-1:0]     mac_out_result,
   input  logic [31:0]          mac_out_data,
   input  logic                 mac_done
);

   localparam int unsigned IN_WORDS = (IN_BYTES + NUM_LANES - 1) / NUM_LANES;
   localparam logic [NUM_LANES-1:0] TAIL_VALID = tail_mask(IN_BYTES);

   seq_state_e state_q, state_d;
   logic [AW-1:0] w_q, w_d, g_q, g_d, rd_w;
   logic [1:0]    n_q, n_d;
   logic          relu_q, relu_d, err_q, err_d;
   logic [31:0]   feat_q, feat_d, wgt_q, wgt_d, bias_q, bias_d, wdata_q, wdata_d;
   logic [3:0][ACC_W-1:0] res_q, res_d;
   logic [31:0]   wgt_lin;
   logic          beat_issue, beat_done, beat_tmo;

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      n_d     = n_q;
      g_d     = g_q;
      relu_d  = relu_q;
      err_d   = err_q;
      feat_d  = feat_q;
      wgt_d   = wgt_q;
      bias_d  = bias_q;
      wdata_d = wdata_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_FLUSH;
            relu_d  = relu_en;
            err_d   = 1'b0;
            w_d     = '0;
            n_d     = '0;
            g_d     = '0;
         end
         S_FLUSH: if (beat_done) state_d = S_RD;
         S_RD: begin
            feat_d  = feat_rdata;
            wgt_d   = wgt_rdata;
            state_d = S_MAC;
         end
         S_MAC: if (beat_done) begin
            w_d     = w_q + 1'b1;
            state_d = (w_q == AW'(IN_WORDS - 1)) ? S_CAPT : S_RD;
         end
         S_CAPT: begin
            res_d[n_q] = mac_out_result;
            n_d        = n_q + 1'b1;
            w_d        = '0;
            state_d    = (n_q == 2'd3) ? S_BRD : S_FLUSH;
         end
         S_BRD: begin
            bias_d  = bias_rdata;
            state_d = S_BIAS;
         end
         S_BIAS: if (beat_done) begin
            wdata_d = mac_out_data;
            state_d = S_WR;
         end
         S_WR: begin
            g_d     = g_q + 1'b1;
            state_d = (g_q == AW'(OUT_GROUPS - 1)) ? S_FIN : S_FLUSH;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (beat_tmo) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
      end
   end

   assign beat_issue = is_beat(state_d) && (state_d != state_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         n_q     <= '0;
         g_q     <= '0;
         relu_q  <= 1'b0;
         err_q   <= 1'b0;
         feat_q  <= '0;
         wgt_q   <= '0;
         bias_q  <= '0;
         wdata_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         n_q     <= n_d;
         g_q     <= g_d;
         relu_q  <= relu_d;
         err_q   <= err_d;
         feat_q  <= feat_d;
         wgt_q   <= wgt_d;
         bias_q  <= bias_d;
         wdata_q <= wdata_d;
         res_q   <= res_d;
      end
   end

   mac_beat_handshake #(.TIMEOUT(TIMEOUT)) u_beat (
      .clk        (clk),
      .rstn       (rstn),
      .issue_i    (beat_issue),
      .mac_done_i (mac_done),
      .mac_en_o   (mac_en),
      .complete_o (beat_done),
      .timeout_o  (beat_tmo)
   );

   // Memories sample the address on the edge entering RD, so during MAC the
   // address already points at the following word.
   assign rd_w    = (state_q == S_MAC) ? w_q + 1'b1 : w_q;
   assign wgt_lin = (32'(g_q) * NUM_LANES + 32'(n_q)) * IN_WORDS + 32'(rd_w);

   assign feat_addr         = rd_w;
   assign wgt_addr          = wgt_lin[AW-1:0];
   assign bias_addr         = g_q;
   assign busy              = (state_q != S_IDLE) && (state_q != S_FIN);
   assign layer_done        = (state_q == S_FIN);
   assign error             = err_q;
   assign out_we            = (state_q == S_WR);
   assign out_addr          = g_q;
   assign out_wdata         = wdata_q;
   assign mac_flush         = (state_q == S_FLUSH);
   assign mac_bias_add      = (state_q == S_BIAS);
   assign mac_relu          = relu_q;
   assign mac_valid         = (state_q != S_MAC) ? '0 :
                              (w_q == AW'(IN_WORDS - 1)) ? TAIL_VALID : '1;
   assign mac_input_feature = feat_q;
   assign mac_weight        = wgt_q;
   assign mac_bias          = bias_q;
   assign mac_result0       = res_q[0];
   assign mac_result1       = res_q[1];
   assign mac_result2       = res_q[2];
   assign mac_result3       = res_q[3];

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a mock 4-lane MAC controller
// and registered-read feature/weight/bias memories.
module tb_fc_layer_sequencer;

   localparam int unsigned IN_BYTES   = 6;
   localparam int unsigned OUT_GROUPS = 2;
   localparam int unsigned AW         = 16;
   localparam int unsigned TIMEOUT    = 40;
   // 2 groups x (4 x (FLUSH 4 + 2 x (RD 1 + MAC 4) + CAPT 1) + BRD 1 + BIAS 4 + WR 1) + FIN
   localparam int LAYER_CYC = 133;

   logic        clk = 1'b0;
   logic        rstn, start, relu_en;
   logic        busy, layer_done, error;
   logic [15:0] feat_addr, wgt_addr, bias_addr, out_addr;
   logic [31:0] feat_rdata, wgt_rdata, bias_rdata, out_wdata;
   logic        out_we, mac_en, mac_flush, mac_bias_add, mac_relu;
   logic [3:0]  mac_valid;
   logic [31:0] mac_input_feature, mac_weight, mac_bias, mac_out_data;
   logic [25:0] mac_result0, mac_result1, mac_result2, mac_result3, mac_out_result;
   logic        mac_done;

   always #5 clk = ~clk;

   fc_layer_sequencer #(
      .IN_BYTES(IN_BYTES), .OUT_GROUPS(OUT_GROUPS), .AW(AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .relu_en(relu_en),
      .busy(busy), .layer_done(layer_done), .error(error),
      .feat_addr(feat_addr), .feat_rdata(feat_rdata),
      .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
      .bias_addr(bias_addr), .bias_rdata(bias_rdata),
      .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata),
      .mac_en(mac_en), .mac_flush(mac_flush), .mac_bias_add(mac_bias_add),
      .mac_relu(mac_relu), .mac_valid(mac_valid),
      .mac_input_feature(mac_input_feature), .mac_weight(mac_weight), .mac_bias(mac_bias),
      .mac_result0(mac_result0), .mac_result1(mac_result1),
      .mac_result2(mac_result2), .mac_result3(mac_result3),
      .mac_out_result(mac_out_result), .mac_out_data(mac_out_data), .mac_done(mac_done)
   );

   // ---------------- memories (1-cycle read latency) ----------------
   logic [31:0] fmem [64];
   logic [31:0] wmem [64];
   logic [31:0] bmem [64];

   always @(posedge clk) begin
      feat_rdata <= fmem[feat_addr[5:0]];
      wgt_rdata  <= wmem[wgt_addr[5:0]];
      bias_rdata <= bmem[bias_addr[5:0]];
   end

   // ---------------- mock MAC controller ----------------
   function automatic logic signed [25:0] lane_dot(input logic [31:0] f, input logic [31:0] w,
                                                   input logic [3:0] v);
      logic signed [25:0] s;
      logic signed [7:0]  a, b;
      logic signed [15:0] p;
      s = '0;
      for (int k = 0; k < 4; k++) begin
         if (v[k]) begin
            a = f[8*k +: 8];
            b = w[8*k +: 8];
            p = a * b;
            s = s + p;
         end
      end
      return s;
   endfunction

   function automatic logic [31:0] quant(input logic [25:0] r0, input logic [25:0] r1,
                                         input logic [25:0] r2, input logic [25:0] r3,
                                         input logic [31:0] bias, input logic relu);
      logic [25:0]        r [4];
      logic signed [25:0] rs;
      logic signed [7:0]  bb;
      logic [31:0]        o;
      int                 q;
      r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
      o = '0;
      for (int k = 0; k < 4; k++) begin
         rs = r[k];
         bb = bias[31-8*k -: 8];
         q  = int'(rs >>> 8) + int'(bb);
         if (relu) begin
            if (q < 0) q = 0;
            if (q > 255) q = 255;
         end else begin
            if (q < -128) q = -128;
            if (q > 127) q = 127;
         end
         o[31-8*k -: 8] = q[7:0];
      end
      return o;
   endfunction

   logic               hang;
   logic               ctl_en_prev;
   int                 ctl_cnt;
   logic signed [25:0] acc;
   logic [31:0]        odata;

   // done stays high after a beat until the first edge of the next beat (stale done).
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctl_en_prev <= 1'b0;
         mac_done    <= 1'b0;
         ctl_cnt     <= 0;
         acc         <= '0;
         odata       <= '0;
      end else begin
         ctl_en_prev <= mac_en;
         if (mac_en && !ctl_en_prev) begin
            mac_done <= 1'b0;
            ctl_cnt  <= 1;
         end else if (mac_en && !mac_done && !hang) begin
            ctl_cnt <= ctl_cnt + 1;
            if (ctl_cnt == 2) begin
               mac_done <= 1'b1;
               if (mac_flush)
                  acc <= '0;
               else if (mac_bias_add)
                  odata <= quant(mac_result0, mac_result1, mac_result2, mac_result3,
                                 mac_bias, mac_relu);
               else
                  acc <= acc + lane_dot(mac_input_feature, mac_weight, mac_valid);
            end
         end
      end
   end

   assign mac_out_result = acc;
   assign mac_out_data   = odata;

   // ---------------- monitor ----------------
   int          wr_n = 0, done_n = 0, mb_n = 0, viol_n = 0;
   logic        mon_en_prev = 1'b0;
   logic [15:0] wr_addr [256];
   logic [31:0] wr_data [256];
   logic [3:0]  bvalid  [256];
   logic [31:0] bwgt    [256];
   logic [31:0] bfeat   [256];

   always @(negedge clk) begin
      mon_en_prev <= mac_en;
      if (rstn) begin
         if (out_we && wr_n < 256) begin
            wr_addr[wr_n] <= out_addr;
            wr_data[wr_n] <= out_wdata;
            wr_n          <= wr_n + 1;
         end
         if (layer_done) done_n <= done_n + 1;
         if (mac_en && !mon_en_prev && !mac_flush && !mac_bias_add && mb_n < 256) begin
            bvalid[mb_n] <= mac_valid;
            bwgt[mb_n]   <= mac_weight;
            bfeat[mb_n]  <= mac_input_feature;
            mb_n         <= mb_n + 1;
         end
         if ((mac_flush || mac_bias_add) && mac_valid != 4'b0000) viol_n <= viol_n + 1;
         if (mac_flush && mac_bias_add) viol_n <= viol_n + 1;
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [7:0] fb, input logic [7:0] wb, input logic [31:0] bias);
      // upper two lanes of the odd (tail) words must be masked off by mac_valid
      for (int i = 0; i < 64; i++) begin
         fmem[i] = (i % 2 == 1) ? {8'hEE, 8'hEE, fb, fb} : {4{fb}};
         wmem[i] = (i % 2 == 1) ? {8'hEE, 8'hEE, wb, wb} : {4{wb}};
         bmem[i] = bias;
      end
   endtask

   task automatic run_layer(input logic relu, input int restart_at, output int cyc_o);
      int cyc;
      bit seen;
      @(posedge clk); #1;
      relu_en = relu;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen  = 1'b0;
      cyc   = 0;
      while (!seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (layer_done || error) seen = 1'b1;
      end
      chk("end_reached", {31'b0, seen}, 32'd1);
      if (layer_done) begin
         // start coinciding with the FIN->IDLE edge
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      cyc_o = cyc;
      repeat (3) @(negedge clk);
   endtask

   task automatic layer_case(input string tag, input logic relu, input logic [31:0] exp_w,
                             input int restart_at);
      int w0, d0, cyc;
      w0 = wr_n;
      d0 = done_n;
      run_layer(relu, restart_at, cyc);
      chk({tag, "_latency"}, cyc, LAYER_CYC);
      chk({tag, "_done_cnt"}, done_n - d0, 1);
      chk({tag, "_wr_cnt"}, wr_n - w0, OUT_GROUPS);
      for (int g = 0; g < OUT_GROUPS; g++) begin
         chk($sformatf("%s_addr%0d", tag, g), {16'b0, wr_addr[w0+g]}, g);
         chk($sformatf("%s_data%0d", tag, g), wr_data[w0+g], exp_w);
      end
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_error"}, {31'b0, error}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  b0, w0, d0, cyc;
      bit  hit;
      rstn    = 1'b0;
      start   = 1'b0;
      relu_en = 1'b0;
      hang    = 1'b0;
      fill(8'h10, 8'h10, 32'h0);
      #2;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, layer_done}, 0);
      chk("rst_error", {31'b0, error}, 0);
      chk("rst_out_we", {31'b0, out_we}, 0);
      chk("rst_mac_en", {31'b0, mac_en}, 0);
      chk("rst_valid", {28'b0, mac_valid}, 0);
      chk("rst_wgt_addr", {16'b0, wgt_addr}, 0);
      chk("rst_wdata", out_wdata, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // basic layer, with an extra start pulse mid-layer that must be ignored
      b0 = mb_n;
      layer_case("basic", 1'b0, 32'h06060606, 30);
      chk("basic_res0", {6'b0, mac_result0}, 32'h600);
      chk("basic_res3", {6'b0, mac_result3}, 32'h600);
      chk("basic_mac_beats", mb_n - b0, OUT_GROUPS * 4 * 2);
      chk("basic_valid_w0", {28'b0, bvalid[b0]}, 4'b1111);
      chk("basic_valid_w1", {28'b0, bvalid[b0+1]}, 4'b0011);
      chk("basic_valid_w15", {28'b0, bvalid[b0+15]}, 4'b0011);

      fill(8'h10, 8'h10, 32'h01000000);
      layer_case("bias", 1'b0, 32'h07060606, 0);

      fill(8'h10, 8'hF0, 32'h0);
      layer_case("neg", 1'b0, 32'hFAFAFAFA, 0);
      chk("neg_res1", {6'b0, mac_result1}, 32'h03FFFA00);
      layer_case("neg_relu", 1'b1, 32'h00000000, 0);

      fill(8'h7F, 8'h7F, 32'h0);
      layer_case("sat_relu", 1'b1, 32'hFFFFFFFF, 0);
      layer_case("sat", 1'b0, 32'h7F7F7F7F, 0);

      // address ordering: weight word index tagged into the data
      for (int i = 0; i < 64; i++) begin
         wmem[i] = 32'hA500_0000 + i;
         fmem[i] = 32'h1100_0000 + i;
      end
      b0 = mb_n;
      run_layer(1'b0, 0, cyc);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("wgt_beat%0d", k), bwgt[b0+k], 32'hA500_0000 + k);
         chk($sformatf("feat_beat%0d", k), bfeat[b0+k], 32'h1100_0000 + (k % 2));
      end
      chk("beat_violations", viol_n, 0);

      // controller never answers
      fill(8'h10, 8'h10, 32'h0);
      hang = 1'b1;
      w0 = wr_n;
      d0 = done_n;
      run_layer(1'b0, 0, cyc);
      chk("tmo_cycles", cyc, TIMEOUT + 1);
      chk("tmo_error", {31'b0, error}, 1);
      chk("tmo_busy", {31'b0, busy}, 0);
      chk("tmo_mac_en", {31'b0, mac_en}, 0);
      chk("tmo_writes", wr_n - w0, 0);
      chk("tmo_done", done_n - d0, 0);
      hang = 1'b0;
      layer_case("recover", 1'b0, 32'h06060606, 0);

      // reset in the middle of a MAC beat
      w0 = wr_n;
      d0 = done_n;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mac_en && mac_valid != 4'b0000) begin
            hit = 1'b1;
            break;
         end
      end
      chk("mid_mac_reached", {31'b0, hit}, 1);
      #2 rstn = 1'b0;
      #1;
      chk("mrst_busy", {31'b0, busy}, 0);
      chk("mrst_mac_en", {31'b0, mac_en}, 0);
      chk("mrst_valid", {28'b0, mac_valid}, 0);
      chk("mrst_res0", {6'b0, mac_result0}, 0);
      chk("mrst_feature", mac_input_feature, 0);
      chk("mrst_feat_addr", {16'b0, feat_addr}, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("mrst_writes", wr_n - w0, 0);
      chk("mrst_done", done_n - d0, 0);
      layer_case("post_reset", 1'b0, 32'h06060606, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
